// File: rtl/sram_responder.sv
// sram_responder: single-port word SRAM behind a valid/ready request/response handshake with fixed latency
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_wen/req_addr/req_wdata/req_wmask request side;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response side (rdata = word before access, err = out of range).
module sram_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h80000000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] wmask_q;
  logic [31:0] mem [1<<DEPTH_LOG2];
  logic [31:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic in_range;
  logic access;
  logic unused_ok;
  always_comb begin
    off = addr_q - BASE_ADDR;
    in_range = {1'b0, off} < SPAN;
    idx = off[DEPTH_LOG2+1:2];
    access = state == BUSY && cnt == 4'd0;
  end
  assign req_ready = state == IDLE;
  assign unused_ok = ^req_wmask[7:4];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        wen_q <= req_wen;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask[3:0];
        cnt <= 4'(LATENCY - 1);
        state <= BUSY;
      end
    end else if (state == BUSY) begin
      cnt <= access ? cnt : cnt - 4'd1;
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= in_range ? mem[idx] : 32'd0;
        rsp_err <= !in_range;
        state <= RESP;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= IDLE;
    end
  end
  // storage is never reset; rst still blocks a write landing on the access edge
  always_ff @(posedge clk) begin
    if (!rst && access && in_range && wen_q)
      for (int i = 0; i < 4; i++)
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench driving three responders (LATENCY 2, 3, 1)
module tb_sram_responder;
  typedef struct packed {logic dc; logic err; logic [31:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst [3];
  logic req_valid [3];
  logic req_ready [3];
  logic req_wen [3];
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [7:0] req_wmask [3];
  logic rsp_valid [3];
  logic rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic rsp_err [3];
  exp_t exp_q [3][$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h80000000), .LATENCY(g == 0 ? 2 : g == 1 ? 3 : 1)) dut (
      .clk(clk), .rst(rst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_wen(req_wen[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end
  function automatic int lat_of(input int i);
    return i == 0 ? 2 : i == 1 ? 3 : 1;
  endfunction
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", name, i, act, exp, cycle);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (exp_q[i].size() == 0) chk("unexpected_rsp", i, 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk("rsp_err", i, {31'd0, rsp_err[i]}, {31'd0, e.err});
          if (!e.dc) chk("rsp_rdata", i, rsp_rdata[i], e.d);
        end
      end
    end
  end
  task automatic accept(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready[i];
      @(posedge clk);
    end
    #1;
  endtask
  task automatic issue(input int i, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [7:0] m, input logic dc, input logic err, input logic [31:0] exp);
    exp_q[i].push_back({dc, err, exp});
    req_wen[i] = wen;
    req_addr[i] = a;
    req_wdata[i] = wd;
    req_wmask[i] = m;
  endtask
  task automatic do_req(input int i, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] m, input logic dc, input logic err, input logic [31:0] exp,
                        input int hold);
    bit ok;
    int lat;
    issue(i, wen, a, wd, m, dc, err, exp);
    req_valid[i] = 1'b1;
    accept(i, ok);
    req_valid[i] = 1'b0;
    req_addr[i] = ~a;
    req_wen[i] = ~wen;
    if (!ok) begin
      chk("accept_timeout", i, 32'd0, 32'd1);
      return;
    end
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[i]) lat = k;
    end
    chk("latency", i, lat, lat_of(i));
    if (lat == 0) return;
    if (hold > 0) begin
      rsp_ready[i] = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        chk("bp_valid", i, {31'd0, rsp_valid[i]}, 32'd1);
        chk("bp_rdata", i, rsp_rdata[i], exp);
        chk("bp_req_ready", i, {31'd0, req_ready[i]}, 32'd0);
      end
      rsp_ready[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("idle_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
    chk("idle_req_ready", i, {31'd0, req_ready[i]}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bit ok;
    int prev;
    logic [31:0] b_addr [4] = '{32'h80000100, 32'h80000102, 32'h80000100, 32'h80000101};
    logic [31:0] b_wd [4] = '{32'h01020304, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [7:0] b_m [4] = '{8'h0F, 8'h00, 8'h03, 8'h00};
    logic b_wen [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic b_dc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] b_exp [4] = '{32'h0, 32'h01020304, 32'h01020304, 32'h0102FFFF};
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      req_valid[i] = 1'b0;
      req_wen[i] = 1'b0;
      req_addr[i] = 32'd0;
      req_wdata[i] = 32'd0;
      req_wmask[i] = 8'd0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      chk("reset_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
      chk("reset_rdata", i, rsp_rdata[i], 32'd0);
      chk("reset_err", i, {31'd0, rsp_err[i]}, 32'd0);
      chk("reset_req_ready", i, {31'd0, req_ready[i]}, 32'd1);
    end
    do_req(0, 1, 32'h80000010, 32'hDEADBEEF, 8'h0F, 1, 0, 32'h0, 0);
    do_req(0, 0, 32'h80000010, 32'h0, 8'h00, 0, 0, 32'hDEADBEEF, 0);
    do_req(0, 1, 32'h80000020, 32'hAABBCCDD, 8'h0F, 1, 0, 32'h0, 0);
    do_req(0, 1, 32'h80000022, 32'h11223344, 8'h04, 0, 0, 32'hAABBCCDD, 0);
    do_req(0, 0, 32'h80000020, 32'h0, 8'h00, 0, 0, 32'hAA22CCDD, 0);
    do_req(0, 1, 32'h80000020, 32'hFFFFFFFF, 8'hF0, 0, 0, 32'hAA22CCDD, 0);
    do_req(0, 0, 32'h80000020, 32'h0, 8'h00, 0, 0, 32'hAA22CCDD, 0);
    do_req(0, 0, 32'h7FFFFFFC, 32'h0, 8'h00, 0, 1, 32'h0, 0);
    do_req(0, 0, 32'h80001000, 32'h0, 8'h00, 0, 1, 32'h0, 0);
    do_req(0, 1, 32'h80000000, 32'h0BADC0DE, 8'h0F, 1, 0, 32'h0, 0);
    do_req(0, 1, 32'h80001000, 32'h12345678, 8'h0F, 0, 1, 32'h0, 0);
    do_req(0, 0, 32'h80000000, 32'h0, 8'h00, 0, 0, 32'h0BADC0DE, 0);
    do_req(0, 1, 32'h80000FFC, 32'h5A5AA5A5, 8'h0F, 1, 0, 32'h0, 0);
    do_req(0, 0, 32'h80000FFC, 32'h0, 8'h00, 0, 0, 32'h5A5AA5A5, 5);
    do_req(1, 1, 32'h80000040, 32'hCAFEF00D, 8'h0F, 1, 0, 32'h0, 0);
    req_wen[1] = 1'b1;
    req_addr[1] = 32'h80000040;
    req_wdata[1] = 32'h00000055;
    req_wmask[1] = 8'h01;
    req_valid[1] = 1'b1;
    accept(1, ok);
    req_valid[1] = 1'b0;
    chk("rst_accept", 1, {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    chk("rst_req_ready", 1, {31'd0, req_ready[1]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("rst_no_rsp", 1, {31'd0, rsp_valid[1]}, 32'd0);
    end
    do_req(1, 0, 32'h80000040, 32'h0, 8'h00, 0, 0, 32'hCAFEF00D, 0);
    req_valid[2] = 1'b1;
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      issue(2, b_wen[j], b_addr[j], b_wd[j], b_m[j], b_dc[j], 0, b_exp[j]);
      accept(2, ok);
      chk("b2b_accept", 2, {31'd0, ok}, 32'd1);
      if (j > 0) chk("b2b_spacing", 2, cycle - prev, 32'd3);
      prev = cycle;
    end
    req_valid[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("queue_drain", i, exp_q[i].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
